// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg -- shared definitions for the alu_pipe block.
//   op_e        : 4-bit operation codes (ADD .. MFLO)
//   state_e     : issue state machine states (IDLE, MUL)
//   OP_W        : op-code width
//   shamt_bits(): number of low B-operand bits used as a shift amount
package alu_pipe_pkg;

    localparam int unsigned OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_NOR   = 4'd5,
        OP_SLT   = 4'd6,
        OP_SLTU  = 4'd7,
        OP_SLL   = 4'd8,
        OP_SRL   = 4'd9,
        OP_SRA   = 4'd10,
        OP_LUI   = 4'd11,
        OP_MULT  = 4'd12,
        OP_MULTU = 4'd13,
        OP_MFHI  = 4'd14,
        OP_MFLO  = 4'd15
    } op_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

    function automatic int unsigned shamt_bits(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/alu_pipe_mul.sv
// alu_pipe_mul -- iterative shift-add multiplier, one multiplier bit per cycle.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   start               : load operands and begin (ignored while busy)
//   signed_en           : treat a/b as two's complement
//   a, b                : WIDTH-bit operands
//   busy                : iteration in progress (WIDTH cycles after start)
//   done                : high during the last iteration cycle; product valid then
//   product             : 2*WIDTH-bit product, valid while done is high
module alu_pipe_mul #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               signed_en,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int unsigned CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [CW-1:0]      cnt;
    logic               neg;

    // Signed multiply runs on magnitudes; the sign is re-applied at the end.
    // The most negative value's magnitude still fits as an unsigned WIDTH-bit number.
    assign a_mag = (signed_en && a[WIDTH-1]) ? -a : a;
    assign b_mag = (signed_en && b[WIDTH-1]) ? -b : b;

    assign acc_nxt = mplier[0] ? (acc + mcand) : acc;
    assign done    = busy && (cnt == CW'(WIDTH - 1));
    // Product includes the final partial sum so the caller can capture it on done.
    assign product = neg ? -acc_nxt : acc_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            busy   <= 1'b0;
        end else if (start && !busy) begin
            mcand  <= {{WIDTH{1'b0}}, a_mag};
            acc    <= '0;
            mplier <= b_mag;
            cnt    <= '0;
            neg    <= signed_en && (a[WIDTH-1] ^ b[WIDTH-1]);
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe -- single-issue ALU with a one-entry registered output stage.
// Ops 0-11, 14, 15 complete with latency 1; MULT/MULTU run an iterative
// multiplier for WIDTH cycles and return LO, writing HI/LO.
// Build option: define ALU_PIPE_MULT_EN to include the multiplier, HI/LO and
// the MUL state. Without it, ops 12-15 complete in one cycle as illegal
// (result 0, zero 1, illegal 1).
// Ports:
//   clk, reset_n         : clock, asynchronous active-low reset
//   in_valid / in_ready  : request handshake
//   op, src_sel, a, b_src: op code, B-source select, operand A, packed B sources
//   out_valid / out_ready: result handshake
//   result, zero, illegal: registered result, result==0, unsupported op
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NSRC  = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [OP_W-1:0]         op,
    input  logic [$clog2(NSRC)-1:0] src_sel,
    input  logic [WIDTH-1:0]        a,
    input  logic [NSRC*WIDTH-1:0]   b_src,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        result,
    output logic                    zero,
    output logic                    illegal
);
    localparam int unsigned SW  = $clog2(NSRC);
    localparam int unsigned SHW = shamt_bits(WIDTH);

    op_e              opc;
    state_e           state;
    state_e           state_nxt;
    logic [WIDTH-1:0] b;
    logic [SHW-1:0]   shamt;
    logic             accept;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ill;
    logic             load;
    logic [WIDTH-1:0] load_res;
    logic             load_ill;

`ifdef ALU_PIPE_MULT_EN
    logic               is_mul;
    logic               mul_start;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
`endif

    assign opc = op_e'(op);

    // Out-of-range selects fall back to source 0.
    always_comb begin
        b = b_src[WIDTH-1:0];
        for (int unsigned k = 1; k < NSRC; k++) begin
            if (src_sel == SW'(k)) begin
                b = b_src[k*WIDTH +: WIDTH];
            end
        end
    end

    assign shamt    = b[SHW-1:0];
    assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (opc)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOR:  alu_res = ~(a | b);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = $signed(a) >>> shamt;
            OP_LUI:  alu_res = b << (WIDTH / 2);
`ifdef ALU_PIPE_MULT_EN
            OP_MFHI: alu_res = hi;
            OP_MFLO: alu_res = lo;
            default: alu_res = '0;
`else
            default: alu_ill = 1'b1;
`endif
        endcase
    end

`ifdef ALU_PIPE_MULT_EN
    assign is_mul    = (opc == OP_MULT) || (opc == OP_MULTU);
    assign mul_start = accept && is_mul;

    alu_pipe_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (mul_start),
        .signed_en (opc == OP_MULT),
        .a         (a),
        .b         (b),
        .busy      (mul_busy),
        .done      (mul_done),
        .product   (mul_prod)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi <= '0;
            lo <= '0;
        end else if (mul_done) begin
            hi <= mul_prod[2*WIDTH-1:WIDTH];
            lo <= mul_prod[WIDTH-1:0];
        end
    end
`endif

    always_comb begin
        state_nxt = state;
`ifdef ALU_PIPE_MULT_EN
        case (state)
            ST_IDLE: if (mul_start) state_nxt = ST_MUL;
            ST_MUL:  if (mul_done || !mul_busy) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
`else
        state_nxt = ST_IDLE;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A multiply issue frees the output slot at acceptance; the slot is
    // refilled from the multiplier when it finishes (no issue is possible
    // in between, so the two load sources never collide).
    always_comb begin
        load     = accept;
        load_res = alu_res;
        load_ill = alu_ill;
`ifdef ALU_PIPE_MULT_EN
        if (is_mul) begin
            load = 1'b0;
        end
        if (mul_done) begin
            load     = 1'b1;
            load_res = mul_prod[WIDTH-1:0];
            load_ill = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
            illegal   <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            result    <= load_res;
            zero      <= (load_res == '0);
            illegal   <= load_ill;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe -- self-checking bench for alu_pipe (WIDTH=32, NSRC=3).
// Covers both builds; multiplier scenarios compile only with ALU_PIPE_MULT_EN.
module tb_alu_pipe;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [1:0]  src_sel;
    logic [31:0] a;
    logic [95:0] b_src;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    alu_pipe #(
        .WIDTH (32),
        .NSRC  (3)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src_sel   (src_sel),
        .a         (a),
        .b_src     (b_src),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick_b(input logic [95:0] bs, input logic [1:0] sel);
        case (sel)
            2'd1:    return bs[63:32];
            2'd2:    return bs[95:64];
            default: return bs[31:0];
        endcase
    endfunction

    // Returns {illegal, result}.
    function automatic logic [32:0] ref_alu(input int unsigned o, input logic [31:0] x, input logic [31:0] y);
        logic [31:0]  r;
        logic         ill;
        int unsigned  sh;
        sh  = y % 32;
        r   = '0;
        ill = 1'b0;
        case (o)
            0:  r = x + y;
            1:  r = x - y;
            2:  r = x & y;
            3:  r = x | y;
            4:  r = x ^ y;
            5:  r = ~(x | y);
            6:  r = (int'(x) < int'(y)) ? 32'd1 : 32'd0;
            7:  r = (x < y) ? 32'd1 : 32'd0;
            8:  r = x << sh;
            9:  r = x >> sh;
            10: begin
                r = x >> sh;
                if (x[31] && sh != 0) r = r | ~(32'hFFFF_FFFF >> sh);
            end
            11: r = y * 32'd65536;
`ifdef ALU_PIPE_MULT_EN
            14: r = m_hi;
            15: r = m_lo;
`endif
            default: ill = 1'b1;
        endcase
        return {ill, r};
    endfunction

    function automatic int unsigned rand_op();
        int unsigned o;
`ifdef ALU_PIPE_MULT_EN
        o = $urandom_range(0, 13);
        if (o >= 12) o = o + 2;
`else
        o = $urandom_range(0, 15);
`endif
        return o;
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op        = 4'd0;
        src_sel   = 2'd0;
        a         = '0;
        b_src     = '0;
        m_hi      = '0;
        m_lo      = '0;
        repeat (3) tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++;
        if (result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
        checks++;
        if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b want 1", zero); end
        checks++;
        if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b want 0", illegal); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_add_wrap();
        op = 4'd0; a = 32'hFFFF_FFFF; b_src = {32'h1234_5678, 32'h9ABC_DEF0, 32'd1}; src_sel = 2'd0;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL add_in_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 32'd0 || zero !== 1'b1 || illegal !== 1'b0)
            begin errors++; $display("FAIL add_wrap: got v=%b r=%h z=%b i=%b want v=1 r=0 z=1 i=0", out_valid, result, zero, illegal); end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_slt();
        op = 4'd6; a = 32'hFFFF_FFFE; b_src = {32'h0, 32'd1, 32'h5}; src_sel = 2'd1;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || result !== 32'd1 || zero !== 1'b0)
            begin errors++; $display("FAIL slt_signed: got v=%b r=%h z=%b want v=1 r=1 z=0", out_valid, result, zero); end
        op = 4'd7;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 32'd0 || zero !== 1'b1)
            begin errors++; $display("FAIL sltu: got v=%b r=%h z=%b want v=1 r=0 z=1", out_valid, result, zero); end
        tick();
    endtask

    task automatic test_src_sel();
        op = 4'd0; a = 32'h0000_0100; b_src = {32'h0003_0000, 32'h0000_2000, 32'h0000_0010};
        src_sel = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        checks++;
        if (result !== 32'h0003_0100) begin errors++; $display("FAIL src_sel2: got %h want 00030100", result); end
        src_sel = 2'd3;
        tick();
        in_valid = 1'b0;
        checks++;
        if (result !== 32'h0000_0110) begin errors++; $display("FAIL src_sel_oob: got %h want 00000110", result); end
        tick();
    endtask

    task automatic test_back_to_back();
        op = 4'd3; src_sel = 2'd0;
        a = 32'h0000_000F; b_src = {64'd0, 32'h0000_00F0};
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || result !== 32'h0000_00FF)
            begin errors++; $display("FAIL b2b_first: got v=%b r=%h want v=1 r=000000ff", out_valid, result); end
        out_ready = 1'b0;
        a = 32'h0000_0100; b_src = {64'd0, 32'h0000_0001};
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall_ready: got %b want 0", in_ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || result !== 32'h0000_00FF || in_ready !== 1'b0)
                begin errors++; $display("FAIL b2b_hold: got v=%b r=%h rdy=%b want v=1 r=000000ff rdy=0", out_valid, result, in_ready); end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_release_ready: got %b want 1", in_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b1 || result !== 32'h0000_0101)
            begin errors++; $display("FAIL b2b_second: got v=%b r=%h want v=1 r=00000101", out_valid, result); end
        a = 32'h0000_3000; b_src = {64'd0, 32'h0000_0004};
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 32'h0000_3004)
            begin errors++; $display("FAIL b2b_third: got v=%b r=%h want v=1 r=00003004", out_valid, result); end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_random();
        logic [32:0] exp;
        out_ready = 1'b1;
        for (int n = 0; n < 200; n++) begin
            op      = 4'(rand_op());
            a       = rand_word();
            b_src   = {rand_word(), rand_word(), rand_word()};
            src_sel = 2'($urandom_range(0, 3));
            in_valid = 1'b1;
            exp = ref_alu(int'(op), a, pick_b(b_src, src_sel));
            #1;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL rand_in_ready: op=%0d got %b want 1", op, in_ready); end
            tick();
            checks++;
            if (out_valid !== 1'b1 || result !== exp[31:0] || zero !== (exp[31:0] == 32'd0) || illegal !== exp[32])
                begin errors++; $display("FAIL rand_op%0d: got v=%b r=%h z=%b i=%b want v=1 r=%h z=%b i=%b", op, out_valid, result, zero, illegal, exp[31:0], (exp[31:0] == 32'd0), exp[32]); end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_stream();
        logic        exp_v;
        logic [32:0] exp_r;
        logic [32:0] cand;
        logic        acc;
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        exp_v = 1'b0;
        exp_r = '0;
        for (int n = 0; n < 300; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            op        = 4'(rand_op());
            a         = rand_word();
            b_src     = {rand_word(), rand_word(), rand_word()};
            src_sel   = 2'($urandom_range(0, 3));
            cand = ref_alu(int'(op), a, pick_b(b_src, src_sel));
            #2;
            checks++;
            if (in_ready !== (!exp_v || out_ready))
                begin errors++; $display("FAIL stream_in_ready: got %b want %b", in_ready, (!exp_v || out_ready)); end
            acc = in_valid && (!exp_v || out_ready);
            tick();
            if (acc) begin
                exp_v = 1'b1;
                exp_r = cand;
            end else if (exp_v && out_ready) begin
                exp_v = 1'b0;
            end
            checks++;
            if (out_valid !== exp_v || (exp_v && (result !== exp_r[31:0] || illegal !== exp_r[32])))
                begin errors++; $display("FAIL stream_out: got v=%b r=%h i=%b want v=%b r=%h i=%b", out_valid, result, illegal, exp_v, exp_r[31:0], exp_r[32]); end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
    endtask

`ifdef ALU_PIPE_MULT_EN
    task automatic test_mult();
        logic stall_ok;
        op = 4'd12; a = 32'hFFFF_FFFF; b_src = {64'd0, 32'd2}; src_sel = 2'd0;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        stall_ok = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (in_ready !== 1'b0 || out_valid !== 1'b0) stall_ok = 1'b0;
            tick();
        end
        checks++;
        if (!stall_ok) begin errors++; $display("FAIL mult_busy: got early ready/valid want rdy=0 v=0 for 32 cycles"); end
        checks++;
        if (out_valid !== 1'b1 || result !== 32'hFFFF_FFFE || illegal !== 1'b0)
            begin errors++; $display("FAIL mult_result: got v=%b r=%h i=%b want v=1 r=fffffffe i=0", out_valid, result, illegal); end
        m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFFE;
        op = 4'd14; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 32'hFFFF_FFFF)
            begin errors++; $display("FAIL mfhi: got v=%b r=%h want v=1 r=ffffffff", out_valid, result); end
        tick();
    endtask

    task automatic test_mult_random();
        logic [63:0] p;
        logic [31:0] bv;
        int          wait_cyc;
        for (int n = 0; n < 6; n++) begin
            op      = (n % 2 == 0) ? 4'd12 : 4'd13;
            a       = rand_word();
            b_src   = {rand_word(), rand_word(), rand_word()};
            src_sel = 2'($urandom_range(0, 3));
            bv      = pick_b(b_src, src_sel);
            if (op == 4'd12) p = 64'(longint'($signed(a)) * longint'($signed(bv)));
            else             p = {32'd0, a} * {32'd0, bv};
            in_valid = 1'b1; out_ready = 1'b1;
            tick();
            in_valid = 1'b0;
            wait_cyc = 1;
            while (out_valid !== 1'b1 && wait_cyc < 40) begin
                tick();
                wait_cyc++;
            end
            checks++;
            if (wait_cyc != 33) begin errors++; $display("FAIL mult_latency: got %0d want 33", wait_cyc); end
            checks++;
            if (result !== p[31:0] || zero !== (p[31:0] == 32'd0))
                begin errors++; $display("FAIL mult_lo op%0d a=%h b=%h: got r=%h z=%b want r=%h", op, a, bv, result, zero, p[31:0]); end
            m_hi = p[63:32]; m_lo = p[31:0];
            op = 4'd14; in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            checks++;
            if (result !== m_hi) begin errors++; $display("FAIL mult_hi op%0d: got %h want %h", n, result, m_hi); end
            tick();
        end
    endtask

    task automatic test_reset_mult();
        logic never;
        op = 4'd13; a = 32'h1234_5679; b_src = {64'd0, 32'h0000_0003}; src_sel = 2'd0;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        m_hi = '0; m_lo = '0;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmul_in_ready: got %b want 1", in_ready); end
        never = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (out_valid !== 1'b0) never = 1'b0;
            tick();
        end
        checks++;
        if (!never) begin errors++; $display("FAIL rstmul_no_result: got out_valid=1 want 0"); end
        op = 4'd15; in_valid = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || result !== 32'd0 || zero !== 1'b1)
            begin errors++; $display("FAIL rstmul_mflo: got v=%b r=%h z=%b want v=1 r=0 z=1", out_valid, result, zero); end
        op = 4'd14;
        tick();
        in_valid = 1'b0;
        checks++;
        if (result !== 32'd0) begin errors++; $display("FAIL rstmul_mfhi: got %h want 0", result); end
        tick();
    endtask
`else
    task automatic test_illegal();
        out_ready = 1'b1;
        for (int o = 12; o < 16; o++) begin
            op = 4'(o); a = $urandom(); b_src = {$urandom(), $urandom(), $urandom()};
            src_sel = 2'($urandom_range(0, 3));
            in_valid = 1'b1;
            tick();
            checks++;
            if (out_valid !== 1'b1 || result !== 32'd0 || zero !== 1'b1 || illegal !== 1'b1 || in_ready !== 1'b1)
                begin errors++; $display("FAIL illegal_op%0d: got v=%b r=%h z=%b i=%b rdy=%b want v=1 r=0 z=1 i=1 rdy=1", o, out_valid, result, zero, illegal, in_ready); end
        end
        op = 4'd0; a = 32'd5; b_src = {64'd0, 32'd6}; src_sel = 2'd0;
        tick();
        in_valid = 1'b0;
        checks++;
        if (illegal !== 1'b0 || result !== 32'd11)
            begin errors++; $display("FAIL illegal_clear: got i=%b r=%h want i=0 r=0000000b", illegal, result); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_add_wrap();
        test_slt();
        test_src_sel();
        test_back_to_back();
`ifdef ALU_PIPE_MULT_EN
        test_mult();
        test_mult_random();
`endif
        test_random();
        test_stream();
`ifdef ALU_PIPE_MULT_EN
        test_reset_mult();
`else
        test_illegal();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (power of 2, 8..64).
REQ-002 SHALL have parameter NSRC, default 2, number of selectable B-operand sources (>=2).
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk  in  1  rising-edge clock.
REQ-005 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port in_valid  in  1  request present.
REQ-007 SHALL have port in_ready  out  1  request accepted when in_valid&&in_ready.
REQ-008 SHALL have port op  in  4  operation code.
REQ-009 SHALL have port src_sel  in  $clog2(NSRC)  B-operand source select.
REQ-010 SHALL have port a  in  WIDTH  operand A.
REQ-011 SHALL have port b_src  in  NSRC*WIDTH  packed B sources, source k at bits [k*WIDTH +: WIDTH].
REQ-012 SHALL have port out_valid  out  1  result present.
REQ-013 SHALL have port out_ready  in  1  result consumed when out_valid&&out_ready.
REQ-014 SHALL have port result  out  WIDTH  registered result.
REQ-015 SHALL have port zero  out  1  result==0.
REQ-016 SHALL have port illegal  out  1  op unsupported in this build; qualified by out_valid.

Function
REQ-017 Op codes SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed), 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 LUI (b<<WIDTH/2), 12 MULT, 13 MULTU, 14 MFHI, 15 MFLO.
REQ-018 B operand SHALL be b_src[src_sel]; src_sel>=NSRC SHALL select source 0.
REQ-019 Shift amount SHALL be the low $clog2(WIDTH) bits of the selected B operand.
REQ-020 ADD/SUB SHALL wrap modulo 2^WIDTH; SLT/SLTU SHALL return 1 or 0 zero-extended.
REQ-021 Ops 0-11, 14, 15 SHALL produce result, zero and out_valid on the cycle after acceptance (latency 1).
REQ-022 in_ready SHALL equal (state==IDLE) && (!out_valid || out_ready), allowing back-to-back issue with 1 result/cycle.
REQ-023 While out_valid && !out_ready, result, zero and illegal SHALL hold stable.
REQ-024 State machine SHALL have states IDLE and MUL; IDLE->MUL on acceptance of MULT/MULTU; MUL->IDLE after WIDTH iteration cycles.
REQ-025 MULT (signed) / MULTU SHALL write the 2*WIDTH product to internal HI (upper) and LO (lower) on leaving MUL.
REQ-026 On leaving MUL, out_valid SHALL assert with result=LO, total latency WIDTH+1 cycles from acceptance.
REQ-027 MFHI/MFLO SHALL return HI/LO as of the last completed multiply; no issue is possible during MUL, so no hazard exists.
REQ-028 illegal SHALL be 0 for every op when the multiplier is compiled in.

Reset
REQ-029 reset_n low SHALL force state=IDLE, out_valid=0, result=0, zero=1, illegal=0, HI=0, LO=0, iteration count=0.
REQ-030 Reset during MUL SHALL abort the multiply with no result and HI/LO cleared; in_ready SHALL be 1 on the first cycle after release.

Configuration
REQ-031 Macro ALU_PIPE_MULT_EN SHALL compile in the multiplier, HI/LO and the MUL state.
REQ-032 Without ALU_PIPE_MULT_EN, ops 12-15 SHALL complete in 1 cycle with result=0, zero=1, illegal=1; the state machine SHALL stay in IDLE.

Structure
REQ-033 Package alu_pipe_pkg SHALL hold the op-code enum, the state enum and shift-width helper constants.
REQ-034 The iterative shift-add multiplier SHALL be sub-module alu_pipe_mul (start, signed_en, busy, done, 2*WIDTH product).

Verification
REQ-035 ADD a=0xFFFFFFFF, src0=1, src_sel=0 -> next cycle result=0, zero=1, out_valid=1.
REQ-036 SLT a=0xFFFFFFFE, src1=1, src_sel=1 -> result=1; SLTU with same operands -> result=0.
REQ-037 Three back-to-back ORs with out_ready held low after the first -> in_ready drops, result holds first value until out_ready=1, all three delivered in order.
REQ-038 MULT a=0xFFFFFFFF, b=2 (with macro) -> in_ready=0 for 32 cycles, out_valid on cycle 33 with result=0xFFFFFFFE; then MFHI -> 0xFFFFFFFF.
REQ-039 reset_n pulsed low 5 cycles into a MULTU -> out_valid never asserts for it; subsequent MFLO -> 0.
REQ-040 Build without ALU_PIPE_MULT_EN, MULT issued -> 1-cycle result=0, zero=1, illegal=1.
